// File: rtl/vmac_pkg.sv
// Shared types and constants for the vector multiply-accumulate engine.
package vmac_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH_A,
      FETCH_B,
      ACC,
      WRITE,
      DONE
   } vmac_state_e;

   localparam int unsigned SHIFT_W      = 6;
   localparam int unsigned STAT_W       = 16;
   localparam int unsigned STAT_BUSY    = 0;
   localparam int unsigned STAT_DONE    = 1;
   localparam int unsigned STAT_ERR     = 2;
   localparam int unsigned STAT_OVF     = 3;
   localparam int unsigned STAT_IDX_LSB = 4;
   localparam int unsigned STAT_IDX_W   = STAT_W - STAT_IDX_LSB;

endpackage

// File: rtl/vmac_if.sv
// SRAM access port of the engine; master = engine side, slave = memory side.
interface vmac_if #(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 32
) ();

   logic              eng_rd_en;
   logic [ADDR_W-1:0] eng_rd_addr;
   logic [DATA_W-1:0] eng_rd_data;
   logic              eng_wr_en;
   logic [ADDR_W-1:0] eng_wr_addr;
   logic [DATA_W-1:0] eng_wr_data;

   modport master (
      output eng_rd_en, eng_rd_addr, eng_wr_en, eng_wr_addr, eng_wr_data,
      input  eng_rd_data
   );

   modport slave (
      input  eng_rd_en, eng_rd_addr, eng_wr_en, eng_wr_addr, eng_wr_data,
      output eng_rd_data
   );

endinterface

// File: rtl/vmac_scale.sv
// Result scaling: arithmetic right shift of the accumulator, then either
// saturation to signed DATA_W (VMAC_SATURATE_EN defined) or plain truncation.
module vmac_scale #(
   parameter int unsigned ACC_W   = 40,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned SHIFT_W = 6
) (
   input  logic [ACC_W-1:0]   acc,
   input  logic [SHIFT_W-1:0] shift,
   output logic [DATA_W-1:0]  data_c,
   output logic               clip_c
);

   logic signed [ACC_W-1:0] shifted;

   // Shift amounts at or beyond the accumulator width collapse to pure sign fill
   always_comb begin
      shifted = '0;
      if (32'(shift) >= ACC_W) begin
         shifted = {ACC_W{acc[ACC_W-1]}};
      end else begin
         shifted = $signed(acc) >>> shift;
      end
   end

`ifdef VMAC_SATURATE_EN
   localparam int unsigned HI_W = ACC_W - DATA_W + 1;

   logic [HI_W-1:0] hi;
   logic            fits;

   assign hi   = shifted[ACC_W-1:DATA_W-1];
   assign fits = (&hi) || !(|hi);

   always_comb begin
      data_c = shifted[DATA_W-1:0];
      clip_c = 1'b0;
      if (!fits) begin
         clip_c = 1'b1;
         data_c = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                   : {1'b0, {(DATA_W-1){1'b1}}};
      end
   end
`else
   logic unused_shift_hi;

   assign data_c          = shifted[DATA_W-1:0];
   assign clip_c          = 1'b0;
   assign unused_shift_hi = ^shifted[ACC_W-1:DATA_W];
`endif

endmodule

// File: rtl/vmac_engine.sv
// Vector multiply-accumulate engine: sum(A[i]*B[i]) over N elements, scaled
// result written to rw_base+N. Optional saturation via VMAC_SATURATE_EN.
module vmac_engine
   import vmac_pkg::*;
#(
   parameter int unsigned ADDR_W = 13,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OP_W   = 16,
   parameter int unsigned ACC_W  = 40
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               clr,
   input  logic [ADDR_W-1:0]  cfg_len,
   input  logic [SHIFT_W-1:0] cfg_shift,
   input  logic [ADDR_W-1:0]  calc_base,
   input  logic [ADDR_W-1:0]  rw_base,
   vmac_if.master             mem,
   output logic [STAT_W-1:0]  stat,
   output logic               done_irq
);

   localparam int unsigned PROD_W = 2 * OP_W;

   vmac_state_e              state;
   logic [ADDR_W-1:0]        len_q;
   logic [ADDR_W-1:0]        base_a_q;
   logic [ADDR_W-1:0]        base_b_q;
   logic [ADDR_W-1:0]        idx_q;
   logic [SHIFT_W-1:0]       shift_q;
   logic [ACC_W-1:0]         acc_q;
   logic signed [OP_W-1:0]   a_q;
   logic                     busy_q;
   logic                     done_q;
   logic                     err_q;
   logic                     ovf_q;

   logic signed [PROD_W-1:0] prod;
   logic [ACC_W-1:0]         acc_nxt;
   logic [DATA_W-1:0]        scaled_c;
   logic                     clip_c;
   logic                     last_c;
   logic                     unused_rd_hi;

   // B arrives on the read port during ACC; the product uses it directly
   assign prod         = a_q * $signed(mem.eng_rd_data[OP_W-1:0]);
   assign acc_nxt      = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
   assign last_c       = (idx_q == len_q - ADDR_W'(1));
   assign unused_rd_hi = ^mem.eng_rd_data[DATA_W-1:OP_W];

   vmac_scale #(
      .ACC_W  (ACC_W),
      .DATA_W (DATA_W),
      .SHIFT_W(SHIFT_W)
   ) u_scale (
      .acc   (acc_nxt),
      .shift (shift_q),
      .data_c(scaled_c),
      .clip_c(clip_c)
   );

   always_comb begin
      stat                           = '0;
      stat[STAT_BUSY]                = busy_q;
      stat[STAT_DONE]                = done_q;
      stat[STAT_ERR]                 = err_q;
      stat[STAT_OVF]                 = ovf_q;
      stat[STAT_W-1:STAT_IDX_LSB]    = STAT_IDX_W'(idx_q);
   end

   // Control FSM; every strobe is registered for the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         len_q           <= '0;
         base_a_q        <= '0;
         base_b_q        <= '0;
         idx_q           <= '0;
         shift_q         <= '0;
         acc_q           <= '0;
         a_q             <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         err_q           <= 1'b0;
         ovf_q           <= 1'b0;
         done_irq        <= 1'b0;
         mem.eng_rd_en   <= 1'b0;
         mem.eng_rd_addr <= '0;
         mem.eng_wr_en   <= 1'b0;
         mem.eng_wr_addr <= '0;
         mem.eng_wr_data <= '0;
      end else begin
         done_irq <= 1'b0;
         if (clr) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            ovf_q  <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  len_q    <= cfg_len;
                  shift_q  <= cfg_shift;
                  base_a_q <= calc_base;
                  base_b_q <= rw_base;
                  acc_q    <= '0;
                  idx_q    <= '0;
                  done_q   <= 1'b0;
                  err_q    <= 1'b0;
                  ovf_q    <= 1'b0;
                  if (cfg_len == '0) begin
                     state    <= DONE;
                     err_q    <= 1'b1;
                     done_q   <= 1'b1;
                     done_irq <= 1'b1;
                  end else begin
                     state           <= FETCH_A;
                     busy_q          <= 1'b1;
                     mem.eng_rd_en   <= 1'b1;
                     mem.eng_rd_addr <= calc_base;
                  end
               end
            end

            FETCH_A: begin
               state           <= FETCH_B;
               mem.eng_rd_en   <= 1'b1;
               mem.eng_rd_addr <= base_b_q + idx_q;
            end

            FETCH_B: begin
               state         <= ACC;
               a_q           <= $signed(mem.eng_rd_data[OP_W-1:0]);
               mem.eng_rd_en <= 1'b0;
            end

            ACC: begin
               acc_q <= acc_nxt;
               idx_q <= idx_q + ADDR_W'(1);
               if (last_c) begin
                  state           <= WRITE;
                  mem.eng_wr_en   <= 1'b1;
                  mem.eng_wr_addr <= base_b_q + len_q;
                  mem.eng_wr_data <= scaled_c;
                  if (clip_c) begin
                     ovf_q <= 1'b1;
                  end
               end else begin
                  state           <= FETCH_A;
                  mem.eng_rd_en   <= 1'b1;
                  mem.eng_rd_addr <= base_a_q + idx_q + ADDR_W'(1);
               end
            end

            WRITE: begin
               state         <= DONE;
               mem.eng_wr_en <= 1'b0;
               busy_q        <= 1'b0;
               done_q        <= 1'b1;
               done_irq      <= 1'b1;
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vmac_engine.sv
// Scoreboard bench for vmac_engine: directed runs push expected SRAM/done
// events; a negedge monitor pops and compares whenever the DUT strobes.
module tb_vmac_engine;

   localparam int unsigned ADDR_W = 13;
   localparam int unsigned DATA_W = 32;

   localparam int EV_RD = 0;
   localparam int EV_WR = 1;
   localparam int EV_DN = 2;

   typedef struct {
      int          kind;
      logic [12:0] addr;
      logic [31:0] data;
      logic [31:0] mask;
      int          cyc;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        clr = 1'b0;
   logic [12:0] cfg_len = '0;
   logic [5:0]  cfg_shift = '0;
   logic [12:0] calc_base = '0;
   logic [12:0] rw_base = '0;
   logic [15:0] stat;
   logic        done_irq;

   logic [31:0] mem [0:8191];
   ev_t         exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          edge_cnt = 0;
   int          start_edge = 0;

   vmac_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sram ();

   vmac_engine #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .OP_W  (16),
      .ACC_W (40)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .clr      (clr),
      .cfg_len  (cfg_len),
      .cfg_shift(cfg_shift),
      .calc_base(calc_base),
      .rw_base  (rw_base),
      .mem      (sram),
      .stat     (stat),
      .done_irq (done_irq)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      edge_cnt <= edge_cnt + 1;
      if (sram.eng_rd_en === 1'b1) sram.eng_rd_data <= mem[sram.eng_rd_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic push(input int kind, input logic [12:0] addr, input logic [31:0] data,
                       input logic [31:0] mask, input int cyc);
      ev_t e;
      e.kind = kind; e.addr = addr; e.data = data; e.mask = mask; e.cyc = cyc;
      exp_q.push_back(e);
   endtask

   task automatic push_run(input logic [12:0] a, input logic [12:0] b, input int n,
                           input logic [31:0] res, input logic [15:0] st);
      for (int k = 0; k < n; k++) begin
         push(EV_RD, 13'(a + 13'(k)), '0, '0, 3 * k + 1);
         push(EV_RD, 13'(b + 13'(k)), '0, '0, 3 * k + 2);
      end
      push(EV_WR, 13'(b + 13'(n)), res, 32'hFFFF_FFFF, 3 * n + 1);
      push(EV_DN, '0, 32'(st), 32'h0000_FFFF, 3 * n + 2);
   endtask

   task automatic observe(input int kind, input logic [12:0] addr, input logic [31:0] data);
      ev_t e;
      int  cyc;
      cyc = edge_cnt - start_edge;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h cycle=%0d, required no event",
                  kind, addr, data, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.addr != addr || ((e.data ^ data) & e.mask) != 0 || e.cyc != cyc) begin
            n_err++;
            $display("FAIL event: got kind=%0d addr=%h data=%h cycle=%0d, required kind=%0d addr=%h data=%h(mask %h) cycle=%0d",
                     kind, addr, data, cyc, e.kind, e.addr, e.data, e.mask, e.cyc);
         end
      end
   endtask

   // Monitor: every strobe the DUT presents must match the next expected event
   always @(negedge clk) begin
      if (sram.eng_rd_en === 1'b1) observe(EV_RD, sram.eng_rd_addr, '0);
      if (sram.eng_wr_en === 1'b1) observe(EV_WR, sram.eng_wr_addr, sram.eng_wr_data);
      if (done_irq === 1'b1)       observe(EV_DN, '0, 32'(stat));
   end

   task automatic kick(input logic [12:0] n, input logic [12:0] a, input logic [12:0] b,
                       input logic [5:0] sh, input logic with_clr);
      @(negedge clk);
      cfg_len    = n;
      calc_base  = a;
      rw_base    = b;
      cfg_shift  = sh;
      start      = 1'b1;
      clr        = with_clr;
      start_edge = edge_cnt;
      @(negedge clk);
      start = 1'b0;
      clr   = 1'b0;
   endtask

   task automatic goto(input int k);
      while (edge_cnt - start_edge < k) @(negedge clk);
   endtask

   task automatic drain(input int n);
      goto(3 * n + 4);
      check("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = '0;
      for (int i = 0; i < 4; i++) begin
         mem[13'h010 + i] = 32'(i + 1);
         mem[13'h100 + i] = 32'(i + 5);
         mem[13'h040 + i] = 32'h0000_7FFF;
         mem[13'h400 + i] = 32'h0000_7FFF;
      end
      mem[13'h020] = 32'h0000_FFFD;
      mem[13'h300] = 32'hABCD_FFFD;
      for (int i = 0; i < 3; i++) mem[13'h050 + i] = 32'd1;
      mem[13'h1FFE] = 32'd2;
      mem[13'h1FFF] = 32'd3;
      mem[13'h0000] = 32'd4;
      mem[13'h060]  = 32'h0000_FFFD;
      mem[13'h600]  = 32'd3;

      // Reset state
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_stat", 32'(stat), 32'h0);
      check("rst_strobes", {29'd0, sram.eng_rd_en, sram.eng_wr_en, done_irq}, 32'h0);
      check("rst_rd_addr", 32'(sram.eng_rd_addr), 32'h0);
      check("rst_wr_bus", 32'(sram.eng_wr_addr) | sram.eng_wr_data, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      // Basic dot product, with an ignored start in mid-run
      push_run(13'h010, 13'h100, 4, 32'd70, 16'h0042);
      kick(13'd4, 13'h010, 13'h100, 6'd0, 1'b0);
      check("busy_c1", 32'(stat), 32'h0001);
      goto(4);
      check("idx_c4", 32'(stat), 32'h0011);
      goto(5);
      cfg_len   = 13'd1;
      calc_base = 13'h200;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain(4);
      check("idle_after_run", 32'(stat), 32'h0042);

      // Zero length: error, no SRAM access, done_irq at cycle 1
      push(EV_DN, '0, 32'h0000_0006, 32'h0000_0006, 1);
      kick(13'd0, 13'h010, 13'h100, 6'd0, 1'b0);
      drain(0);

      // Negative operands, shift 1; upper SRAM bits ignored
      push_run(13'h020, 13'h300, 1, 32'd4, 16'h0012);
      kick(13'd1, 13'h020, 13'h300, 6'd1, 1'b0);
      drain(1);

      // Result too large for 32 bits, then a clr after the run
`ifdef VMAC_SATURATE_EN
      push_run(13'h040, 13'h400, 4, 32'h7FFF_FFFF, 16'h004A);
`else
      push_run(13'h040, 13'h400, 4, 32'hFFFC_0004, 16'h0042);
`endif
      kick(13'd4, 13'h040, 13'h400, 6'd0, 1'b0);
      drain(4);
      goto(20);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_flags", 32'(stat), 32'h0040);

      // Address wrap of the B vector and the result location
      push_run(13'h050, 13'h1FFE, 3, 32'd9, 16'h0032);
      kick(13'd3, 13'h050, 13'h1FFE, 6'd0, 1'b0);
      drain(3);

      // start+clr together, shift beyond accumulator width
      push_run(13'h060, 13'h600, 1, 32'hFFFF_FFFF, 16'h0012);
      kick(13'd1, 13'h060, 13'h600, 6'd63, 1'b1);
      check("start_clr_c1", 32'(stat), 32'h0001);
      drain(1);

      // Reset in mid-run: reads up to cycle 5, then nothing
      push(EV_RD, 13'h010, '0, '0, 1);
      push(EV_RD, 13'h100, '0, '0, 2);
      push(EV_RD, 13'h011, '0, '0, 4);
      push(EV_RD, 13'h101, '0, '0, 5);
      kick(13'd4, 13'h010, 13'h100, 6'd0, 1'b0);
      goto(5);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_stat", 32'(stat), 32'h0);
      check("midrst_strobes", {29'd0, sram.eng_rd_en, sram.eng_wr_en, done_irq}, 32'h0);
      rst = 1'b0;
      drain(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
